// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, control-word layout and PC-select encodings for the
// pipelined control unit.
package pipe_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Control word field positions, MSB first:
  // {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}
  localparam int RW       = 7;
  localparam int M2R      = 6;
  localparam int MR       = 5;
  localparam int MW       = 4;
  localparam int ALUSRC   = 3;
  localparam int ALUOP_HI = 2;
  localparam int ALUOP_LO = 1;
  localparam int RDST     = 0;

  // Control words per instruction class
  localparam logic [7:0] CTRL_RTYPE = 8'h81;
  localparam logic [7:0] CTRL_ORI   = 8'h8A;
  localparam logic [7:0] CTRL_ADDI  = 8'h8C;
  localparam logic [7:0] CTRL_LW    = 8'hEC;
  localparam logic [7:0] CTRL_SW    = 8'h1C;
  localparam logic [7:0] CTRL_NONE  = 8'h00;

  // Next-PC source select
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word plus the branch/jump class
// flags, the undefined-opcode flag and whether the instruction reads rt.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter bit BNE_EN = 1'b1
) (
  input  logic [5:0] opcode,
  output logic [7:0] ctrl,
  output logic       is_beq,
  output logic       is_bne,
  output logic       is_j,
  output logic       illegal,
  output logic       reads_rt
);

  // Opcode lookup; anything not listed is flagged and decodes as a bubble
  always_comb begin
    ctrl     = CTRL_NONE;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    illegal  = 1'b0;
    reads_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl     = CTRL_RTYPE;
        reads_rt = 1'b1;
      end
      OP_ORI:  ctrl = CTRL_ORI;
      OP_ADDI: ctrl = CTRL_ADDI;
      OP_LW:   ctrl = CTRL_LW;
      OP_SW: begin
        ctrl     = CTRL_SW;
        reads_rt = 1'b1;
      end
      OP_BEQ: begin
        is_beq   = 1'b1;
        reads_rt = 1'b1;
      end
      OP_BNE: begin
        if (BNE_EN) begin
          is_bne   = 1'b1;
          reads_rt = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J:    is_j = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID instruction, carries the control
// word and destination through EX, MEM and WB, and resolves load-use and
// branch-operand hazards into PC / IF/ID stall, flush and next-PC select.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W    = 8,
  parameter int REG_AW    = 5,
  parameter bit HAZARD_EN = 1'b1,
  parameter bit BNE_EN    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              eq_i,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CTRL_W-1:0] mem_ctrl_o,
  output logic [CTRL_W-1:0] wb_ctrl_o,
  output logic [REG_AW-1:0] ex_dst_o,
  output logic [REG_AW-1:0] mem_dst_o,
  output logic [REG_AW-1:0] wb_dst_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic [1:0]        pc_sel_o,
  output logic              illegal_o
);

  logic [7:0]        dec_ctrl;
  logic              dec_beq;
  logic              dec_bne;
  logic              dec_j;
  logic              dec_illegal;
  logic              dec_reads_rt;

  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_AW-1:0] id_dst;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  logic [CTRL_W-1:0] ctrl_p0;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [CTRL_W-1:0] ctrl_p2;
  logic [REG_AW-1:0] dst_p0;
  logic [REG_AW-1:0] dst_p1;
  logic [REG_AW-1:0] dst_p2;
  logic              illegal_q;

  logic              load_use;
  logic              br_ex_dep;
  logic              br_mem_dep;
  logic              stall;
  logic              take_br;

  // Immediate/funct bits are datapath business, not needed for control
  logic              instr_unused;
  assign instr_unused = ^instr_i[10:0];

  ctrl_decode #(
    .BNE_EN(BNE_EN)
  ) u_dec (
    .opcode  (instr_i[31:26]),
    .ctrl    (dec_ctrl),
    .is_beq  (dec_beq),
    .is_bne  (dec_bne),
    .is_j    (dec_j),
    .illegal (dec_illegal),
    .reads_rt(dec_reads_rt)
  );

  // ID stage: operand fields and destination selection
  always_comb begin
    rs      = REG_AW'(instr_i[25:21]);
    rt      = REG_AW'(instr_i[20:16]);
    rd      = REG_AW'(instr_i[15:11]);
    id_ctrl = CTRL_W'(dec_ctrl);
    if (!id_ctrl[RW])
      id_dst = '0;
    else if (id_ctrl[RDST])
      id_dst = rd;
    else
      id_dst = rt;
  end

  // Hazard detection against the instructions in EX and MEM
  always_comb begin
    load_use   = ctrl_p0[MR] && (dst_p0 != '0) &&
                 ((dst_p0 == rs) || (dec_reads_rt && (dst_p0 == rt)));
    br_ex_dep  = ctrl_p0[RW] && (dst_p0 != '0) &&
                 ((dst_p0 == rs) || (dst_p0 == rt));
    br_mem_dep = ctrl_p1[MR] && (dst_p1 != '0) &&
                 ((dst_p1 == rs) || (dst_p1 == rt));
    stall      = HAZARD_EN &&
                 (load_use || ((dec_beq || dec_bne) && (br_ex_dep || br_mem_dep)));
  end

  // Next-PC selection; a stall suppresses redirects until it clears
  always_comb begin
    take_br      = (dec_beq && eq_i) || (dec_bne && !eq_i);
    pc_write_o   = !stall;
    ifid_write_o = !stall;
    ifid_flush_o = 1'b0;
    pc_sel_o     = PC_SEL_SEQ;
    if (!stall) begin
      if (dec_j) begin
        pc_sel_o     = PC_SEL_JMP;
        ifid_flush_o = 1'b1;
      end else if (take_br) begin
        pc_sel_o     = PC_SEL_BR;
        ifid_flush_o = 1'b1;
      end
    end
  end

  // Control pipeline ID/EX -> EX/MEM -> MEM/WB, plus sticky illegal flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_p0   <= '0;
      ctrl_p1   <= '0;
      ctrl_p2   <= '0;
      dst_p0    <= '0;
      dst_p1    <= '0;
      dst_p2    <= '0;
      illegal_q <= 1'b0;
    end else begin
      // ID -> EX: a stall injects a bubble
      ctrl_p0   <= stall ? '0 : id_ctrl;
      dst_p0    <= stall ? '0 : id_dst;
      // EX -> MEM
      ctrl_p1   <= ctrl_p0;
      dst_p1    <= dst_p0;
      // MEM -> WB
      ctrl_p2   <= ctrl_p1;
      dst_p2    <= dst_p1;
      illegal_q <= illegal_q | dec_illegal;
    end
  end

  assign ex_ctrl_o  = ctrl_p0;
  assign mem_ctrl_o = ctrl_p1;
  assign wb_ctrl_o  = ctrl_p2;
  assign ex_dst_o   = dst_p0;
  assign mem_dst_o  = dst_p1;
  assign wb_dst_o   = dst_p2;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: reset, forwarding-free sequence,
// load-use stall, load-branch double stall, jumps/branches, illegal opcode,
// mid-run reset, and a HAZARD_EN=0 build sharing the same stimulus.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        eq;

  logic [7:0]  ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_dst, mem_dst, wb_dst;
  logic        pc_write, ifid_write, ifid_flush, illegal;
  logic [1:0]  pc_sel;

  logic [7:0]  n_ex_ctrl, n_mem_ctrl, n_wb_ctrl;
  logic [4:0]  n_ex_dst, n_mem_dst, n_wb_dst;
  logic        n_pc_write, n_ifid_write, n_ifid_flush, n_illegal;
  logic [1:0]  n_pc_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.CTRL_W(8), .REG_AW(5), .HAZARD_EN(1'b1), .BNE_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .eq_i(eq),
    .ex_ctrl_o(ex_ctrl), .mem_ctrl_o(mem_ctrl), .wb_ctrl_o(wb_ctrl),
    .ex_dst_o(ex_dst), .mem_dst_o(mem_dst), .wb_dst_o(wb_dst),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .pc_sel_o(pc_sel), .illegal_o(illegal)
  );

  pipe_ctrl_unit #(.CTRL_W(8), .REG_AW(5), .HAZARD_EN(1'b0), .BNE_EN(1'b1)) dut_nohz (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .eq_i(eq),
    .ex_ctrl_o(n_ex_ctrl), .mem_ctrl_o(n_mem_ctrl), .wb_ctrl_o(n_wb_ctrl),
    .ex_dst_o(n_ex_dst), .mem_dst_o(n_mem_dst), .wb_dst_o(n_wb_dst),
    .pc_write_o(n_pc_write), .ifid_write_o(n_ifid_write), .ifid_flush_o(n_ifid_flush),
    .pc_sel_o(n_pc_sel), .illegal_o(n_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  initial begin
    // Reset held two cycles with a load in IF/ID
    rst   = 1'b1;
    eq    = 1'b0;
    instr = i_ins(6'b100011, 5'd0, 5'd1);
    tick();
    settle();
    chk("rst_ex_ctrl", ex_ctrl, 8'h00);
    chk("rst_mem_ctrl", mem_ctrl, 8'h00);
    chk("rst_wb_ctrl", wb_ctrl, 8'h00);
    chk("rst_ex_dst", ex_dst, 5'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_pc_write", pc_write, 1'b1);
    chk("rst_ifid_write", ifid_write, 1'b1);
    tick();
    chk("rst2_ex_ctrl", ex_ctrl, 8'h00);
    chk("rst2_wb_dst", wb_dst, 5'd0);
    chk("rst2_illegal", illegal, 1'b0);

    // addi $1 then add $3,$1,$2: no stall
    rst   = 1'b0;
    instr = i_ins(6'b001000, 5'd0, 5'd1);
    settle();
    chk("addi_pc_write", pc_write, 1'b1);
    tick();
    chk("addi_ex_ctrl", ex_ctrl, 8'h8C);
    chk("addi_ex_dst", ex_dst, 5'd1);
    instr = r_ins(5'd1, 5'd2, 5'd3);
    settle();
    chk("add_no_stall", pc_write, 1'b1);
    tick();
    chk("add_ex_ctrl", ex_ctrl, 8'h81);
    chk("add_ex_dst", ex_dst, 5'd3);
    chk("addi_mem_ctrl", mem_ctrl, 8'h8C);
    instr = 32'h0;
    tick();
    chk("addi_wb_dst", wb_dst, 5'd1);
    chk("addi_wb_ctrl", wb_ctrl, 8'h8C);
    chk("add_mem_dst", mem_dst, 5'd3);

    // lw $2 then add $4,$2,$3: one stall cycle
    instr = i_ins(6'b100011, 5'd0, 5'd2);
    settle();
    chk("lw_pc_write", pc_write, 1'b1);
    tick();
    chk("lw_ex_ctrl", ex_ctrl, 8'hEC);
    chk("lw_ex_dst", ex_dst, 5'd2);
    instr = r_ins(5'd2, 5'd3, 5'd4);
    settle();
    chk("lu_pc_write", pc_write, 1'b0);
    chk("lu_ifid_write", ifid_write, 1'b0);
    chk("lu_pc_sel", pc_sel, 2'b00);
    chk("lu_flush", ifid_flush, 1'b0);
    chk("nohz_pc_write", n_pc_write, 1'b1);
    chk("nohz_ifid_write", n_ifid_write, 1'b1);
    tick();
    chk("lu_bubble_ex", ex_ctrl, 8'h00);
    chk("lu_bubble_dst", ex_dst, 5'd0);
    chk("lu_lw_mem", mem_ctrl, 8'hEC);
    settle();
    chk("lu_release", pc_write, 1'b1);
    tick();
    chk("lu_add_ex_ctrl", ex_ctrl, 8'h81);
    chk("lu_add_ex_dst", ex_dst, 5'd4);

    // lw $5 then beq $5,$0 with eq=1: two stall cycles then redirect
    instr = i_ins(6'b100011, 5'd0, 5'd5);
    settle();
    chk("lw5_pc_write", pc_write, 1'b1);
    tick();
    chk("lw5_ex_dst", ex_dst, 5'd5);
    instr = i_ins(6'b000100, 5'd5, 5'd0);
    eq    = 1'b1;
    settle();
    chk("lb1_pc_write", pc_write, 1'b0);
    chk("lb1_pc_sel", pc_sel, 2'b00);
    chk("lb1_flush", ifid_flush, 1'b0);
    tick();
    chk("lb1_bubble", ex_ctrl, 8'h00);
    chk("lb1_mem_dst", mem_dst, 5'd5);
    settle();
    chk("lb2_pc_write", pc_write, 1'b0);
    chk("lb2_ifid_write", ifid_write, 1'b0);
    chk("lb2_pc_sel", pc_sel, 2'b00);
    tick();
    settle();
    chk("lb3_wb_dst", wb_dst, 5'd5);
    chk("lb3_pc_write", pc_write, 1'b1);
    chk("lb3_pc_sel", pc_sel, 2'b01);
    chk("lb3_flush", ifid_flush, 1'b1);
    tick();
    chk("beq_ex_ctrl", ex_ctrl, 8'h00);
    instr = 32'h0;
    eq    = 1'b0;
    settle();
    chk("post_br_pc_sel", pc_sel, 2'b00);
    chk("post_br_flush", ifid_flush, 1'b0);
    tick();

    // j: immediate redirect
    instr = {6'b000010, 26'h0000100};
    settle();
    chk("j_pc_sel", pc_sel, 2'b10);
    chk("j_flush", ifid_flush, 1'b1);
    chk("j_pc_write", pc_write, 1'b1);
    tick();

    // bne $1,$2: not taken with eq=1, taken with eq=0
    instr = i_ins(6'b000101, 5'd1, 5'd2);
    eq    = 1'b1;
    settle();
    chk("bne_nt_pc_sel", pc_sel, 2'b00);
    chk("bne_nt_flush", ifid_flush, 1'b0);
    eq = 1'b0;
    settle();
    chk("bne_t_pc_sel", pc_sel, 2'b01);
    chk("bne_t_flush", ifid_flush, 1'b1);
    tick();

    // Undefined opcode: sticky flag, bubble in EX
    instr = 32'hFC00_0000;
    settle();
    chk("ill_before_edge", illegal, 1'b0);
    tick();
    chk("ill_set", illegal, 1'b1);
    chk("ill_ex_ctrl", ex_ctrl, 8'h00);
    instr = i_ins(6'b001000, 5'd0, 5'd7);
    tick();
    chk("ill_held", illegal, 1'b1);
    chk("ill_next_ex_ctrl", ex_ctrl, 8'h8C);
    tick();
    chk("ill_held2", illegal, 1'b1);
    chk("ill_mem_ctrl", mem_ctrl, 8'h8C);

    // Reset mid-run discards everything in flight
    rst = 1'b1;
    tick();
    chk("mrst_ex_ctrl", ex_ctrl, 8'h00);
    chk("mrst_mem_ctrl", mem_ctrl, 8'h00);
    chk("mrst_wb_ctrl", wb_ctrl, 8'h00);
    chk("mrst_mem_dst", mem_dst, 5'd0);
    chk("mrst_illegal", illegal, 1'b0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
